// File: rtl/comma_aligner_if.sv
// Signal bundle between the raw-word source, the comma aligner and the 8b/10b decoder.
// The master drives unaligned words and decoder feedback. The slave (the aligner) returns aligned symbols and lock status.
interface comma_aligner_if;
    logic [9:0] iData;
    logic       DECODE_ERROR;
    logic [9:0] oData;
    logic       oValid;
    logic       LOCKED;
    logic       COMMA_DET;
    logic [3:0] ALIGN_OFFSET;

    modport master (
        output iData, DECODE_ERROR,
        input  oData, oValid, LOCKED, COMMA_DET, ALIGN_OFFSET
    );

    modport slave (
        input  iData, DECODE_ERROR,
        output oData, oValid, LOCKED, COMMA_DET, ALIGN_OFFSET
    );
endinterface

// File: rtl/comma_aligner.sv
// K28.5 word aligner: searches a 20-bit window for the comma, qualifies the offset with a lock FSM, emits aligned symbols.
// Define LOCK_LOSS_EN to let consecutive DECODE_ERROR words drop lock. Without it, LOCKED is sticky until reset.
module comma_aligner #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned GAP_MAX  = 64,
    parameter int unsigned ERR_MAX  = 4
) (
    input  logic           INTERCLK,
    input  logic           RESET_N,
    comma_aligner_if.slave bus
);
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam int unsigned GW = $clog2(GAP_MAX + 1);
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [9:0]    prev;
    logic [19:1]   win;
    logic [9:0]    cand [10];
    logic [9:0]    match;
    logic          any_match;
    logic [3:0]    first_k;
    logic [9:0]    cur_cand;
    logic [3:0]    align_offset, align_offset_nxt;
    logic [CW-1:0] comma_cnt, comma_cnt_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [9:0]    odata_q;
    logic          comma_det_q;
    logic          valid_q;

`ifdef LOCK_LOSS_EN
    localparam int unsigned EW = $clog2(ERR_MAX + 1);
    logic [EW-1:0] err_cnt, err_cnt_nxt;
`else
    logic unused_decode_error;
    assign unused_decode_error = bus.DECODE_ERROR;
`endif

    function automatic logic is_comma(input logic [9:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

    // The final bit of the window can never start a candidate, so it is left out.
    assign win = {prev, bus.iData[9:1]};

    // Downward scan so the lowest matching offset is the one that sticks.
    always_comb begin
        match     = '0;
        first_k   = '0;
        any_match = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cand[k]  = win[19-k -: 10];
            match[k] = is_comma(cand[k]);
        end
        for (int k = 9; k >= 0; k--) begin
            if (match[k]) begin
                first_k   = 4'(k);
                any_match = 1'b1;
            end
        end
        cur_cand = (align_offset < 4'd10) ? cand[align_offset] : '0;
    end

    always_comb begin
        state_nxt        = state;
        align_offset_nxt = align_offset;
        comma_cnt_nxt    = comma_cnt;
        gap_cnt_nxt      = gap_cnt;
`ifdef LOCK_LOSS_EN
        err_cnt_nxt      = err_cnt;
`endif
        case (state)
            ST_HUNT: begin
                if (any_match) begin
                    align_offset_nxt = first_k;
                    comma_cnt_nxt    = CW'(1);
                    gap_cnt_nxt      = '0;
                    state_nxt        = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                // A comma at the current offset outranks one elsewhere in the same window.
                if (match[align_offset]) begin
                    if (comma_cnt < CW'(LOCK_CNT))
                        comma_cnt_nxt = comma_cnt + 1'b1;
                    gap_cnt_nxt = '0;
                    if (comma_cnt_nxt >= CW'(LOCK_CNT))
                        state_nxt = ST_LOCKED;
                end else if (any_match) begin
                    align_offset_nxt = first_k;
                    comma_cnt_nxt    = CW'(1);
                    gap_cnt_nxt      = '0;
                end else if (gap_cnt >= GW'(GAP_MAX - 1)) begin
                    state_nxt     = ST_HUNT;
                    comma_cnt_nxt = '0;
                    gap_cnt_nxt   = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
`ifdef LOCK_LOSS_EN
                if (bus.DECODE_ERROR) begin
                    if (err_cnt >= EW'(ERR_MAX - 1)) begin
                        state_nxt     = ST_HUNT;
                        comma_cnt_nxt = '0;
                        gap_cnt_nxt   = '0;
                        err_cnt_nxt   = '0;
                    end else begin
                        err_cnt_nxt = err_cnt + 1'b1;
                    end
                end else begin
                    err_cnt_nxt = '0;
                end
`endif
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // The output symbol uses the offset held before this edge, so it lags the completing word by one cycle.
    always_ff @(posedge INTERCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_HUNT;
            prev         <= '0;
            align_offset <= '0;
            comma_cnt    <= '0;
            gap_cnt      <= '0;
            odata_q      <= '0;
            comma_det_q  <= 1'b0;
            valid_q      <= 1'b0;
`ifdef LOCK_LOSS_EN
            err_cnt      <= '0;
`endif
        end else begin
            state        <= state_nxt;
            prev         <= bus.iData;
            align_offset <= align_offset_nxt;
            comma_cnt    <= comma_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
            odata_q      <= cur_cand;
            comma_det_q  <= is_comma(cur_cand);
            valid_q      <= (state_nxt == ST_LOCKED);
`ifdef LOCK_LOSS_EN
            err_cnt      <= err_cnt_nxt;
`endif
        end
    end

    assign bus.oData        = odata_q;
    assign bus.COMMA_DET    = comma_det_q;
    assign bus.oValid       = valid_q;
    assign bus.LOCKED       = valid_q;
    assign bus.ALIGN_OFFSET = align_offset;
endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: a symbol table for the offset-3 lock, plus sequences for reset, offset jumps, gap timeout, lock retention and error-driven loss of lock.
module tb_comma_aligner;
    localparam logic [9:0] KN  = 10'b0011111010;
    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] D21 = 10'b1010101010;
    localparam logic [9:0] D00 = 10'b1001110100;

    typedef struct {
        logic [9:0] sym;
        logic       chk_data;
        logic [9:0] exp_data;
        logic       exp_comma;
        logic       exp_locked;
        logic [3:0] exp_offset;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [9:0] last_sym;
    int pass_cnt;
    int total_cnt;
    vec_t vecs [10];

    comma_aligner_if ca_if ();

    comma_aligner dut (
        .INTERCLK(clk),
        .RESET_N (rst_n),
        .bus     (ca_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [9:0] actual, input logic [9:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Words are cut from a serial stream that carries k filler bits ahead of the symbols,
    // so each symbol shows up at candidate k of the window completed by the following word.
    task automatic applyStimulus(input logic [9:0] sym, input int k);
        logic [19:0] tmp;
        @(negedge clk);
        tmp          = {last_sym, sym};
        ca_if.iData  = 10'(tmp >> k);
        last_sym     = sym;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        ca_if.iData        = '0;
        ca_if.DECODE_ERROR = 1'b0;
        last_sym           = D21;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_at_zero(input string tag);
        applyStimulus(D21, 0);
        applyStimulus(KN, 0);
        applyStimulus(KN, 0);
        applyStimulus(KN, 0);
        applyStimulus(D21, 0);
        checkOutput({tag, "_locked"}, 10'(ca_if.LOCKED), 10'd1);
        checkOutput({tag, "_offset"}, 10'(ca_if.ALIGN_OFFSET), 10'd0);
    endtask

    initial begin
        logic       err_seq [8];
        logic       exp_lock_seq [8];
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        ca_if.iData = '0;
        ca_if.DECODE_ERROR = 1'b0;
        last_sym = D21;

        vecs[0] = '{D21, 1'b0, 10'd0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{KN,  1'b0, 10'd0, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{KP,  1'b0, 10'd0, 1'b0, 1'b0, 4'd3};
        vecs[3] = '{KN,  1'b1, KP,    1'b1, 1'b0, 4'd3};
        vecs[4] = '{KP,  1'b1, KN,    1'b1, 1'b1, 4'd3};
        vecs[5] = '{D21, 1'b1, KP,    1'b1, 1'b1, 4'd3};
        vecs[6] = '{KN,  1'b1, D21,   1'b0, 1'b1, 4'd3};
        vecs[7] = '{D00, 1'b1, KN,    1'b1, 1'b1, 4'd3};
        vecs[8] = '{D21, 1'b1, D00,   1'b0, 1'b1, 4'd3};
        vecs[9] = '{D21, 1'b1, D21,   1'b0, 1'b1, 4'd3};

        do_reset();
        #1;
        checkOutput("reset_odata",  ca_if.oData, 10'd0);
        checkOutput("reset_valid",  10'(ca_if.oValid), 10'd0);
        checkOutput("reset_locked", 10'(ca_if.LOCKED), 10'd0);
        checkOutput("reset_offset", 10'(ca_if.ALIGN_OFFSET), 10'd0);

        // Offset-3 lock with alternating running disparity
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sym, 3);
            checkOutput($sformatf("t2_row%0d_locked", i), 10'(ca_if.LOCKED), 10'(vecs[i].exp_locked));
            checkOutput($sformatf("t2_row%0d_valid", i), 10'(ca_if.oValid), 10'(vecs[i].exp_locked));
            checkOutput($sformatf("t2_row%0d_offset", i), 10'(ca_if.ALIGN_OFFSET), 10'(vecs[i].exp_offset));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("t2_row%0d_data", i), ca_if.oData, vecs[i].exp_data);
                checkOutput($sformatf("t2_row%0d_comma", i), 10'(ca_if.COMMA_DET), 10'(vecs[i].exp_comma));
            end
        end

        // Asynchronous reset mid-lock
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_async_odata",  ca_if.oData, 10'd0);
        checkOutput("t1_async_comma",  10'(ca_if.COMMA_DET), 10'd0);
        checkOutput("t1_async_locked", 10'(ca_if.LOCKED), 10'd0);
        checkOutput("t1_async_valid",  10'(ca_if.oValid), 10'd0);
        checkOutput("t1_async_offset", 10'(ca_if.ALIGN_OFFSET), 10'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_sym = D21;
        applyStimulus(D21, 3);
        applyStimulus(KN, 3);
        applyStimulus(D21, 3);
        applyStimulus(KN, 3);
        applyStimulus(D21, 3);
        checkOutput("t1_relock_offset", 10'(ca_if.ALIGN_OFFSET), 10'd3);
        checkOutput("t1_relock_locked", 10'(ca_if.LOCKED), 10'd0);
        checkOutput("t1_relock_valid",  10'(ca_if.oValid), 10'd0);

        // Offset jump while verifying
        do_reset();
        applyStimulus(D21, 5);
        applyStimulus(KN, 5);
        applyStimulus(D21, 5);
        applyStimulus(KN, 5);
        applyStimulus(D21, 5);
        checkOutput("t3_pre_offset", 10'(ca_if.ALIGN_OFFSET), 10'd5);
        applyStimulus(D21, 2);
        applyStimulus(KN, 2);
        applyStimulus(D21, 2);
        checkOutput("t3_jump_offset", 10'(ca_if.ALIGN_OFFSET), 10'd2);
        checkOutput("t3_jump_locked", 10'(ca_if.LOCKED), 10'd0);
        applyStimulus(KN, 2);
        applyStimulus(D21, 2);
        checkOutput("t3_second_locked", 10'(ca_if.LOCKED), 10'd0);
        applyStimulus(KN, 2);
        applyStimulus(D21, 2);
        checkOutput("t3_third_locked", 10'(ca_if.LOCKED), 10'd1);
        checkOutput("t3_third_offset", 10'(ca_if.ALIGN_OFFSET), 10'd2);

        // Gap of 63 data words must not time out
        do_reset();
        applyStimulus(D21, 7);
        applyStimulus(KN, 7);
        applyStimulus(D21, 7);
        checkOutput("t4a_detect_offset", 10'(ca_if.ALIGN_OFFSET), 10'd7);
        repeat (62) applyStimulus(D21, 7);
        applyStimulus(KN, 7);
        applyStimulus(KN, 7);
        checkOutput("t4a_second_locked", 10'(ca_if.LOCKED), 10'd0);
        applyStimulus(D21, 7);
        checkOutput("t4a_third_locked", 10'(ca_if.LOCKED), 10'd1);

        // Gap of 64 data words returns to HUNT
        do_reset();
        applyStimulus(D21, 7);
        applyStimulus(KN, 7);
        repeat (64) applyStimulus(D21, 7);
        applyStimulus(KN, 7);
        checkOutput("t4b_timeout_locked", 10'(ca_if.LOCKED), 10'd0);
        checkOutput("t4b_timeout_offset", 10'(ca_if.ALIGN_OFFSET), 10'd7);
        applyStimulus(KN, 7);
        applyStimulus(KN, 7);
        checkOutput("t4b_two_commas_locked", 10'(ca_if.LOCKED), 10'd0);
        applyStimulus(D21, 7);
        checkOutput("t4b_three_commas_locked", 10'(ca_if.LOCKED), 10'd1);

        // Lock retention against a comma at another offset
        do_reset();
        lock_at_zero("t5");
        applyStimulus(KN, 4);
        applyStimulus(D21, 4);
        applyStimulus(D21, 4);
        checkOutput("t5_keep_offset", 10'(ca_if.ALIGN_OFFSET), 10'd0);
        checkOutput("t5_keep_valid",  10'(ca_if.oValid), 10'd1);
        checkOutput("t5_keep_locked", 10'(ca_if.LOCKED), 10'd1);

        // Decoder errors: a burst of three, one clean word, then four
        do_reset();
        lock_at_zero("t6");
        err_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef LOCK_LOSS_EN
        exp_lock_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_lock_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 8; i++) begin
            ca_if.DECODE_ERROR = err_seq[i];
            applyStimulus(D21, 0);
            checkOutput($sformatf("t6_step%0d_locked", i), 10'(ca_if.LOCKED), 10'(exp_lock_seq[i]));
            checkOutput($sformatf("t6_step%0d_valid", i), 10'(ca_if.oValid), 10'(exp_lock_seq[i]));
        end
        ca_if.DECODE_ERROR = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
